// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One result bit per cycle: shift-add multiply, restoring divide on magnitudes.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             rd_hilo,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    logic [1:0]         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               is_div_r;
    logic               sa_r;
    logic               sb_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;

    logic               sgn_a_s;
    logic               sgn_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH-1:0]   rem_sub_s;
    logic               geq_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // Operand conditioning, one iteration step, and final sign correction.
    always_comb begin
        sgn_a_s    = ~op[0] & rs_val[WIDTH-1];
        sgn_b_s    = ~op[0] & rt_val[WIDTH-1];
        mag_a_s    = neg_if(rs_val, sgn_a_s);
        mag_b_s    = neg_if(rt_val, sgn_b_s);
        // acc holds {partial product, remaining multiplier} during multiply.
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (acc_r[0] ? b_r : ZERO_W)};
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        // acc holds {partial remainder, dividend/quotient bits} during divide.
        rem_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        geq_s      = (rem_sh_s >= {1'b0, b_r});
        rem_sub_s  = rem_sh_s[WIDTH-1:0] - b_r;
        div_next_s = {(geq_s ? rem_sub_s : rem_sh_s[WIDTH-1:0]), acc_r[WIDTH-2:0], geq_s};
        prod_s     = neg2_if(acc_r, sa_r ^ sb_r);
        // Divide by zero leaves the magnitude in the remainder, so re-signing it restores rs_val.
        quo_s      = (b_r == ZERO_W) ? ONES_W : neg_if(acc_r[WIDTH-1:0], sa_r ^ sb_r);
        rem_s      = neg_if(acc_r[2*WIDTH-1:WIDTH], sa_r);
    end

    // Sequencer state, datapath registers and architectural HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            is_div_r <= 1'b0;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            b_r      <= ZERO_W;
            acc_r    <= {(2*WIDTH){1'b0}};
            hi_r     <= ZERO_W;
            lo_r     <= ZERO_W;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        is_div_r <= op[1];
                        sa_r     <= sgn_a_s;
                        sb_r     <= sgn_b_s;
                        b_r      <= mag_b_s;
                        acc_r    <= {ZERO_W, mag_a_s};
                        cnt_r    <= {CNT_W{1'b0}};
                        state_r  <= CALC;
                    end else begin
                        if (wr_hi) begin
                            hi_r <= wr_data;
                        end
                        if (wr_lo) begin
                            lo_r <= wr_data;
                        end
                    end
                end
                CALC: begin
                    acc_r <= is_div_r ? div_next_s : mul_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    if (is_div_r) begin
                        hi_r <= rem_s;
                        lo_r <= quo_s;
                    end else begin
                        hi_r <= prod_s[2*WIDTH-1:WIDTH];
                        lo_r <= prod_s[WIDTH-1:0];
                    end
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign hi    = hi_r;
    assign lo    = lo_r;
    assign done  = done_r;
    assign busy  = (state_r != IDLE);
    assign stall = busy & (start | rd_hilo | wr_hi | wr_lo);

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that sits beside the EX-stage ALU and owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a WIDTH-cycle shift-add or restoring-divide loop.
- Raises a stall to the pipeline hazard logic while a later HI/LO access or a new mul/div collides with an operation in flight.
- Also services MTHI/MTLO writes and supplies HI/LO to the EX result mux.

Parameters:
WIDTH, 32, operand width and iteration count.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
start  in  1  EX holds a valid mul/div instruction.
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled when start accepted.
rs_val  in  WIDTH  operand A (multiplicand / dividend).
rt_val  in  WIDTH  operand B (multiplier / divisor).
rd_hilo  in  1  EX holds MFHI or MFLO.
wr_hi  in  1  MTHI.
wr_lo  in  1  MTLO.
wr_data  in  WIDTH  MTHI/MTLO data.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.
busy  out  1  operation in flight (state != IDLE).
stall  out  1  busy & (start | rd_hilo | wr_hi | wr_lo); combinational.
done  out  1  registered one-cycle pulse on the HI/LO result update.

Behaviour:
- Reset (reset=0, asynchronous, any state including mid-operation):
  - state=IDLE; hi=lo=0; done=0; iteration counter=0; internal operand/partial registers=0.
  - The in-flight operation is discarded.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1: latch op, magnitudes of operands, and sign flags (signed ops only); counter=0; go to CALC.
  - Else wr_hi/wr_lo write wr_data to hi/lo on the edge.
  - Both wr_hi and wr_lo may be asserted together.
  - start has priority over wr_hi/wr_lo if both are asserted; the writes are dropped.
- CALC: one bit per cycle; counter increments; after the WIDTH-th CALC edge go to FIX.
  - Multiply: 2*WIDTH-bit shift-add on magnitudes.
  - Divide: restoring division on magnitudes; quotient bit = 1 when the partial remainder is >= the divisor.
- FIX (one cycle), then IDLE:
  - Apply sign correction and write hi/lo; done=1 for exactly this one cycle.
  - Multiply: {hi,lo} = product; negated when signs differ (MULT only).
  - Divide: lo = quotient, hi = remainder.
  - Signed divide: quotient negated if the operand signs differ; remainder takes the dividend's sign.
- Latency: start edge + WIDTH CALC edges + FIX edge.
  - hi/lo hold the new result after WIDTH+2 rising edges counted from the accepting edge inclusive (34 for WIDTH=32).
- Divide by zero: full latency; lo = all ones, hi = rs_val as latched (raw dividend), for both DIV and DIVU.
- Signed overflow 0x80000000 / -1: lo = 0x80000000, hi = 0 (the natural magnitude result; no special case).
- Collision handling:
  - While busy, start/rd_hilo/wr_hi/wr_lo have no effect on state or hi/lo; they only raise stall.
  - The pipeline re-presents the request on the cycle busy falls.
  - During FIX busy=1, so a request in that cycle stalls once and sees the new hi/lo on the next cycle.
- hi/lo are never changed except by FIX, an idle MTHI/MTLO write, or reset.
- Operands are sampled only at acceptance; later changes to rs_val/rt_val are ignored.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> after 34 edges hi=0xFFFFFFFE, lo=0x00000001; done pulses exactly once; busy high for 33 cycles.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=0x12345678 rt=0 -> lo=0xFFFFFFFF, hi=0x12345678 after 34 edges; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULTU, then assert rd_hilo at cycle 5 and start at cycle 10 -> stall=1 in those cycles, hi/lo unchanged until FIX, second start ignored; stall=0 the cycle after done.
- Idle wr_hi=1 and wr_lo=1 with wr_data=0xA5A5A5A5 -> both update on the next edge; start+wr_lo together while idle -> lo not written, operation begins.
- Assert reset=0 asynchronously at CALC cycle 12 -> busy, done, hi, lo go to 0 immediately; after release a new DIVU 100/7 gives lo=14, hi=2.
